// File: rtl/gemm_tile_ctrl.sv
// Tile sequencer for the systolic-array output data mover: per tile it pulls PE_SIZE
// beats from the output FIFO, waits out the diagonal skew, then holds the write-back window.
module gemm_tile_ctrl #(
    parameter int PE_SIZE = 16,
    parameter int OC      = 64,
    parameter int TILE_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [TILE_W-1:0] num_tiles_i,
    input  logic              abort_i,
    input  logic              fifo_valid_i,
    output logic              fifo_rd_o,
    output logic              mover_en_o,
    output logic              wb_active_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [TILE_W-1:0] tile_idx_o,
    output logic [2:0]        state_dbg
);

    localparam int BW = $clog2(PE_SIZE + 1);
    localparam int CW = $clog2(PE_SIZE * OC + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(PE_SIZE - 1);
    localparam logic [CW-1:0] SKEW_LAST = CW'(PE_SIZE - 2);
    localparam logic [CW-1:0] WIN_LAST  = CW'(PE_SIZE * OC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FEED  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    logic [BW-1:0]     beat_cnt;
    logic [CW-1:0]     cnt;
    logic [TILE_W-1:0] tile_idx;
    logic [TILE_W-1:0] num_q;

    // FIFO handshake: a beat transfers in every FEED cycle where fifo_valid_i is high;
    // fifo_rd_o is the pop for that same cycle, so there is no separate ready.
    assign mover_en_o  = (state == FEED) && fifo_valid_i;
    assign fifo_rd_o   = mover_en_o;
    assign wb_active_o = (state == WRITE);
    assign busy_o      = (state != IDLE);
    assign done_o      = (state == DONE);
    assign tile_idx_o  = tile_idx;
    assign state_dbg   = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            cnt      <= '0;
            tile_idx <= '0;
            num_q    <= '0;
        end else if (abort_i && state != IDLE) begin
            state    <= IDLE;
            beat_cnt <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        num_q    <= num_tiles_i;
                        tile_idx <= '0;
                        beat_cnt <= '0;
                        cnt      <= '0;
                        state    <= (num_tiles_i == '0) ? DONE : FEED;
                    end
                end
                FEED: begin
                    if (fifo_valid_i) begin
                        if (beat_cnt == BEAT_LAST) begin
                            beat_cnt <= '0;
                            cnt      <= '0;
                            state    <= DRAIN;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                // PE_SIZE-1 cycles so the last skewed row lands in the buffer
                DRAIN: begin
                    if (cnt == SKEW_LAST) begin
                        cnt   <= '0;
                        state <= WRITE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (cnt == WIN_LAST) begin
                        cnt <= '0;
                        if (tile_idx == num_q - TILE_W'(1)) begin
                            state <= DONE;
                        end else begin
                            tile_idx <= tile_idx + 1'b1;
                            state    <= FEED;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gemm_tile_ctrl.sv
// Bench for gemm_tile_ctrl: a timeline model built from the tile schedule predicts
// every output for every cycle of a run, with directed and random FIFO/abort stimulus.
module tb_gemm_tile_ctrl;

    localparam int PE_SIZE = 16;
    localparam int OC      = 64;
    localparam int TILE_W  = 8;
    localparam int MAXC    = 4096;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic [TILE_W-1:0] num_tiles_i = '0;
    logic              abort_i = 1'b0;
    logic              fifo_valid_i = 1'b0;
    logic              fifo_rd_o, mover_en_o, wb_active_o, busy_o, done_o;
    logic [TILE_W-1:0] tile_idx_o;
    logic [2:0]        state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // timeline model: phase per cycle (0 idle, 1 feed, 2 drain, 3 write, 4 done)
    bit vld[MAXC];
    int ph[MAXC];
    int tl[MAXC];
    int done_c, end_c;
    int g_pops, g_wbs, g_dones, g_done_at;

    gemm_tile_ctrl #(.PE_SIZE(PE_SIZE), .OC(OC), .TILE_W(TILE_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_tiles_i(num_tiles_i),
        .abort_i(abort_i), .fifo_valid_i(fifo_valid_i), .fifo_rd_o(fifo_rd_o),
        .mover_en_o(mover_en_o), .wb_active_o(wb_active_o), .busy_o(busy_o),
        .done_o(done_o), .tile_idx_o(tile_idx_o), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {19'd0, mover_en_o, fifo_rd_o, wb_active_o, busy_o, done_o, tile_idx_o};
    endfunction

    task automatic build_model(input int n, input int abort_c);
        int t, acc, last;
        for (int c = 0; c < MAXC; c++) begin
            ph[c] = 0;
            tl[c] = 0;
        end
        t = 1;
        last = 0;
        for (int k = 0; k < n; k++) begin
            acc = 0;
            while (acc < PE_SIZE) begin
                ph[t] = 1; tl[t] = k;
                if (vld[t]) acc++;
                t++;
            end
            for (int i = 0; i < PE_SIZE - 1; i++) begin
                ph[t] = 2; tl[t] = k; t++;
            end
            for (int i = 0; i < PE_SIZE * OC; i++) begin
                ph[t] = 3; tl[t] = k; t++;
            end
            last = k;
        end
        ph[t] = 4; tl[t] = last;
        done_c = t;
        end_c = t + 2;
        for (int c = t + 1; c <= end_c; c++) tl[c] = last;
        if (abort_c > 0 && abort_c < done_c) begin
            end_c = abort_c + 3;
            for (int c = abort_c + 1; c <= end_c; c++) begin
                ph[c] = 0;
                tl[c] = tl[abort_c];
            end
        end
    endtask

    // mode: 0 FIFO always valid, 1 valid on odd cycles, 2 random
    task automatic run(input int n, input int mode, input int abort_c, input int st_c,
                       input bit st_done, input int stop_c);
        int ec, e_pops, e_wbs, e_dones, e_done_at;
        logic [31:0] exp;
        bit mov;
        for (int c = 0; c < MAXC; c++)
            vld[c] = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(c % 2) : ($urandom_range(0, 3) != 0);
        build_model(n, abort_c);
        ec = (stop_c > 0) ? stop_c : end_c;
        g_pops = 0; g_wbs = 0; g_dones = 0; g_done_at = 0;
        e_pops = 0; e_wbs = 0; e_dones = 0; e_done_at = 0;
        @(negedge clk);
        start_i = 1'b1;
        num_tiles_i = TILE_W'(n);
        @(posedge clk);
        #1;
        for (int c = 1; c <= ec; c++) begin
            fifo_valid_i = vld[c];
            start_i = (c == st_c) || (st_done && c == done_c);
            abort_i = (c == abort_c);
            @(negedge clk);
            mov = (ph[c] == 1) && vld[c];
            exp = {19'd0, mov, mov, ph[c] == 3, ph[c] != 0, ph[c] == 4, tl[c][7:0]};
            check($sformatf("n%0d_cyc%0d", n, c), dut_vec(), exp);
            if (mov) e_pops++;
            if (ph[c] == 3) e_wbs++;
            if (ph[c] == 4) begin e_dones++; e_done_at = c; end
            if (fifo_rd_o) g_pops++;
            if (wb_active_o) g_wbs++;
            if (done_o) begin g_dones++; g_done_at = c; end
            @(posedge clk);
            #1;
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        fifo_valid_i = 1'b0;
        if (stop_c == 0) begin
            check("pop_count", g_pops, e_pops);
            check("wb_count", g_wbs, e_wbs);
            check("done_count", g_dones, e_dones);
            check("done_cycle", g_done_at, e_done_at);
        end
    endtask

    initial begin
        int n, ab, st;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", dut_vec(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle", dut_vec(), 32'd0);

        // single tile, FIFO always valid
        run(1, 0, 0, 0, 1'b0, 0);
        check("t1_pops", g_pops, 16);
        check("t1_wb_cycles", g_wbs, 1024);
        check("t1_done_cycle", g_done_at, 1056);
        check("t1_tile_idx", tile_idx_o, 0);

        // three back-to-back tiles
        run(3, 0, 0, 0, 1'b0, 0);
        check("t3_pops", g_pops, 48);
        check("t3_done_cycle", g_done_at, 3166);
        check("t3_tile_idx", tile_idx_o, 2);

        // FIFO valid toggling 1,0 during feed
        run(1, 1, 0, 0, 1'b0, 0);
        check("tog_pops", g_pops, 16);

        // abort in write window, then a normal tile
        run(1, 0, 500, 0, 1'b0, 0);
        check("abort_no_done", g_dones, 0);
        run(1, 0, 0, 0, 1'b0, 0);
        check("after_abort_done", g_done_at, 1056);

        // start pulses in FEED and in DONE are ignored; then a zero-tile start
        run(2, 0, 0, 5, 1'b1, 0);
        check("ignored_start_dones", g_dones, 1);
        run(0, 0, 0, 0, 1'b0, 0);
        check("zero_tile_done", g_done_at, 1);
        check("zero_tile_pops", g_pops, 0);

        // random FIFO availability, stray starts and occasional aborts
        for (int r = 0; r < 4; r++) begin
            n  = $urandom_range(1, 3);
            st = $urandom_range(1, 30);
            ab = ($urandom_range(0, 1) == 1) ? $urandom_range(40, 1200) : 0;
            run(n, 2, ab, st, 1'b0, 0);
        end

        // async reset in the middle of DRAIN
        run(1, 0, 0, 0, 1'b0, 20);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check("async_rst_outputs", dut_vec(), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("async_rst_idle", dut_vec(), 32'd0);
        run(1, 0, 0, 0, 1'b0, 0);
        check("post_rst_done", g_done_at, 1056);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gemm_tile_ctrl.md
# gemm_tile_ctrl

Sequencing controller for the systolic-array output data mover. Per tile it reads PE_SIZE beats from the output FIFO into the mover, waits out the diagonal skew, then holds a write-back window of PE_SIZE*OC cycles while the mover streams into mem0. It repeats this for a programmed tile count and reports completion. It sits between the GEMM top-level control and the data mover / output FIFO pair.

## Interface
- PE_SIZE, 16, systolic array dimension; beats per tile feed and skew reference
- OC, 64, output channels; write-back window = PE_SIZE*OC cycles
- TILE_W, 8, width of tile count
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- start_i  in  1  start pulse; sampled only in IDLE
- num_tiles_i  in  TILE_W  tile count; latched when start_i is accepted
- abort_i  in  1  synchronous abort; highest priority after reset
- fifo_valid_i  in  1  output FIFO has a beat available
- fifo_rd_o  out  1  FIFO pop, equal to mover_en_o
- mover_en_o  out  1  data mover enable (one beat written to row-0 buffer)
- wb_active_o  out  1  high during the write-back window
- busy_o  out  1  high in any state except IDLE
- done_o  out  1  one-cycle completion pulse
- tile_idx_o  out  TILE_W  index of the tile in progress (0-based)

## Operation
- States: IDLE, FEED, DRAIN, WRITE, DONE.
- IDLE: if start_i, latch num_tiles_i and clear tile_idx and beat_cnt. Go to DONE if num_tiles_i==0, else go to FEED.
- FEED: mover_en_o = fifo_rd_o = fifo_valid_i. beat_cnt increments on each accepted beat. After beat PE_SIZE is accepted, clear beat_cnt and go to DRAIN. No beat is consumed while fifo_valid_i=0; the state holds with no timeout.
- DRAIN: exactly PE_SIZE-1 cycles, so the last skewed row is written. Then go to WRITE.
- WRITE: wb_active_o=1 for exactly PE_SIZE*OC cycles. On the last cycle, if tile_idx==num_tiles-1 go to DONE; otherwise increment tile_idx and go to FEED.
- DONE: done_o=1 for one cycle, then go to IDLE. tile_idx_o keeps its last value until the next accepted start.
- abort_i in any non-IDLE state: go to IDLE on the next edge. All strobes drop that edge and done_o is not asserted. abort_i in IDLE has no effect.
- start_i outside IDLE is ignored and not queued.
- Counter widths: beat_cnt $clog2(PE_SIZE+1); skew/window counter $clog2(PE_SIZE*OC+1). No wrap-around is permitted within a phase.
- The whole FSM and all counters are registered. Outputs are decoded from state plus fifo_valid_i; the only combinational path is fifo_valid_i -> mover_en_o / fifo_rd_o.

## Timing
- Reset values: state=IDLE; mover_en_o, fifo_rd_o, wb_active_o, busy_o, done_o = 0; tile_idx_o = 0; latched count = 0.
- Reset asserted mid-operation returns the block to IDLE immediately (asynchronous). Outputs follow the reset values in the same cycle.
- start_i sampled at edge E: FEED begins in cycle E+1, and busy_o=1 from E+1.
- With fifo_valid_i held high, per tile:
  - FEED: PE_SIZE cycles
  - DRAIN: PE_SIZE-1 cycles
  - WRITE: PE_SIZE*OC cycles
  - Tile period: 2*PE_SIZE-1+PE_SIZE*OC = 1055 cycles at defaults.
- Single tile at defaults:
  - FEED cycles 1–16, DRAIN 17–31, WRITE 32–1055.
  - done_o=1 in cycle 1056; IDLE and busy_o=0 from cycle 1057.
- Back-to-back tiles: FEED of tile k+1 starts in the cycle directly after the last WRITE cycle of tile k, with no bubble.
- num_tiles_i=0: done_o in cycle E+1, IDLE in E+2. mover_en_o is never asserted.

## Test plan
- Reset, then a single tile with default parameters and fifo_valid_i=1:
  - Exactly 16 mover_en_o cycles (1–16).
  - wb_active_o high for exactly 1024 cycles (32–1055).
  - done_o pulse in cycle 1056; tile_idx_o=0.
- num_tiles_i=3, FIFO always valid:
  - tile_idx_o steps 0→1→2 at the boundaries, 1055 cycles apart.
  - 48 total pops; one done_o pulse in cycle 3166.
- FEED with fifo_valid_i toggling 1,0 each cycle:
  - mover_en_o only in valid cycles.
  - DRAIN entered after the 16th accepted beat (cycle 31).
  - Pop count exactly 16.
- abort_i asserted in cycle 500 (WRITE):
  - IDLE at the next edge, all outputs 0, no done_o.
  - A following start_i runs a full tile normally.
- start_i pulsed during FEED and again in DONE: both ignored, and only one done_o occurs. Then num_tiles_i=0 with start: done_o one cycle later, no pops.
- Async rst asserted in cycle 20 (DRAIN), between clock edges:
  - All outputs go to reset values before the next edge.
  - After release, state=IDLE and tile_idx_o=0.
